ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Multi-cycle iterative divider beside the execute stage; it consumes the operand pair delivered by the ID/EX pipeline register for DIV/DIVU.
- Computes quotient and remainder by 1-bit-per-cycle restoring division.
- The execute stage holds `start_i` high and raises a pipeline stall request until `ready_o` is asserted.
- The result is written to HI (remainder) and LO (quotient).

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  request or hold a division.
- annul_i  in  1  cancel the operation in flight (e.g. branch flush).
- result_o  out  2*DATA_W  {remainder, quotient}.
- ready_o  out  1  result_o valid.

Behaviour:
- Clock and reset:
  - One clock (`clk`); reset (`rst`) is synchronous and active-high.
  - With `rst`=1 at an edge: state=FREE, counter=0, `ready_o`=0, `result_o`=0. This takes priority over every other input, including mid-division.
- Registered outputs: `ready_o` and `result_o` are registers, with no combinational path from any input.
- States: FREE, BYZERO, ON, END.
- FREE:
  - `ready_o`=0, `result_o`=0.
  - If `start_i`=1 and `annul_i`=0:
    - If `opdata2_i`==0, go to BYZERO.
    - Otherwise go to ON with counter=0. Latch |dividend| and |divisor| (magnitudes taken only when `signed_div_i`=1, else raw values). Latch `signed_div_i` and both operand sign bits. Clear the partial remainder.
  - Otherwise stay in FREE.
- BYZERO: next edge goes to END with `result_o`=0 and `ready_o`=1.
- ON:
  - If `annul_i`=1, go to FREE; outputs remain 0 and the partial result is discarded.
  - Else, if counter < DATA_W, perform one step and increment the counter:
    - Shift the next dividend MSB into the partial remainder R (DATA_W+1 bits wide for the compare).
    - If R >= divisor: R -= divisor and shift 1 into the quotient.
    - Else shift 0 into the quotient.
  - Else (counter == DATA_W), go to END. Apply sign correction and load `result_o`; set `ready_o`=1.
- Sign correction (only when the latched signed flag is 1):
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - 0x80000000 / 0xFFFFFFFF (signed) yields quotient 0x80000000, remainder 0; no trap.
- Latency: the `start_i` sampling edge is E0.
  - Normal division: `ready_o` rises after E(DATA_W+1), i.e. E33.
  - Divide by zero: `ready_o` rises after E2.
- END:
  - `ready_o`=1 and `result_o` are held stable while `start_i`=1.
  - When `start_i`=0 at an edge, go to FREE with `ready_o`=0 and `result_o`=0.
  - `annul_i` is ignored in END.
- Operand changes after E0 do not affect the result.
- A new `start_i` is accepted only from FREE. Back-to-back divisions therefore require `start_i` to be low for at least one edge.

Test Plan:
1. Unsigned 100/7 (`signed_div_i`=0), `start_i` held high -> `ready_o`=1 after E33, `result_o`=0x00000002_0000000E; values stay stable while `start_i`=1; `ready_o`=0 one edge after `start_i` drops.
2. Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> `result_o`=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> `result_o`=0x00000001_FFFFFFFD.
3. Divide by zero (any dividend, divisor 0) -> `ready_o`=1 after E2, `result_o`=0. Separately, unsigned 0xFFFFFFFF/0x00000001 -> `result_o`=0x00000000_FFFFFFFF after E33.
4. Annul: start 100/7, assert `annul_i` at E10 -> state FREE, `ready_o` never rises. Then with `start_i` low one edge, start 9/3 -> `result_o`=0x00000000_00000003 after E33 of the new op.
5. Reset mid-operation: `rst`=1 at E20 of a division -> `ready_o`=0, `result_o`=0 next cycle. A fresh 15/4 then completes with `result_o`=0x00000003_00000003.
6. Signed overflow 0x80000000/0xFFFFFFFF -> `result_o`=0x00000000_80000000. Changing `opdata1_i`/`opdata2_i` during ON leaves the result unchanged.

Source files
------------

// File: rtl/ex_div.sv
// ex_div - multi-cycle restoring divider that sits beside the execute stage.
//
// Produces quotient and remainder one bit per clock for DIV (signed) and DIVU
// (unsigned). The execute stage holds start_i and stalls until ready_o is high.
// The result then stays stable for as long as start_i remains high.
//
// Ports
//   clk           clock
//   rst           synchronous reset, active-high
//   signed_div_i  1 = two's complement DIV, 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request or hold a division
//   annul_i       cancel the division in flight (pipeline flush)
//   result_o      {remainder, quotient}, registered
//   ready_o       result_o valid, registered
//
// States
//   state    | meaning
//   S_FREE   | idle; waits for start_i, outputs held at zero
//   S_BYZERO | divisor was zero; two-edge dwell, then a zero result
//   S_ON     | one restoring step per edge until DATA_W steps are done
//   S_END    | result valid; held until start_i drops
//
// CNT_W must satisfy 2**CNT_W > DATA_W so that the counter can reach DATA_W.

module ex_div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   dvd_q;     // dividend magnitude, shifted left one bit per step
    logic [DATA_W-1:0]   dvs_q;     // divisor magnitude
    logic [DATA_W-1:0]   rem_q;     // partial remainder
    logic [DATA_W-1:0]   quot_q;    // quotient bits, shifted in from the LSB
    logic                sgn_q;     // latched signed_div_i
    logic                s1_q;      // dividend sign bit
    logic                s2_q;      // divisor sign bit

    logic [DATA_W-1:0]   op1_mag;
    logic [DATA_W-1:0]   op2_mag;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W-1:0]   rem_sub;
    logic                fits;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    always_comb begin
        op1_mag   = opdata1_i;
        op2_mag   = opdata2_i;
        if (signed_div_i && opdata1_i[DATA_W-1]) begin
            op1_mag = -opdata1_i;
        end
        if (signed_div_i && opdata2_i[DATA_W-1]) begin
            op2_mag = -opdata2_i;
        end

        // The compare needs DATA_W+1 bits: after the shift, R can exceed
        // the largest divisor. The difference itself always fits in DATA_W
        // bits because R < 2*divisor, so it is taken modulo 2**DATA_W.
        rem_shift = {rem_q, dvd_q[DATA_W-1]};
        fits      = (rem_shift >= {1'b0, dvs_q});
        rem_sub   = rem_shift[DATA_W-1:0] - dvs_q;

        // The most negative dividend divided by -1 wraps back to itself.
        // No trap is raised in that case.
        quot_fix  = (sgn_q && (s1_q ^ s2_q)) ? -quot_q : quot_q;
        rem_fix   = (sgn_q && s1_q) ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FREE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            sgn_q    <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        cnt <= '0;
                        if (opdata2_i == '0) begin
                            state <= S_BYZERO;
                        end else begin
                            state  <= S_ON;
                            dvd_q  <= op1_mag;
                            dvs_q  <= op2_mag;
                            rem_q  <= '0;
                            quot_q <= '0;
                            sgn_q  <= signed_div_i;
                            s1_q   <= opdata1_i[DATA_W-1];
                            s2_q   <= opdata2_i[DATA_W-1];
                        end
                    end
                end

                S_BYZERO: begin
                    // The counter provides the second dwell edge, so ready_o
                    // rises after the edge two past the start edge.
                    if (cnt == '0) begin
                        cnt <= CNT_ONE;
                    end else begin
                        state    <= S_END;
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end

                S_ON: begin
                    if (annul_i) begin
                        state    <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else if (cnt != CNT_DONE) begin
                        dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
                        if (fits) begin
                            rem_q  <= rem_sub;
                            quot_q <= {quot_q[DATA_W-2:0], 1'b1};
                        end else begin
                            rem_q  <= rem_shift[DATA_W-1:0];
                            quot_q <= {quot_q[DATA_W-2:0], 1'b0};
                        end
                        cnt <= cnt + CNT_ONE;
                    end else begin
                        state    <= S_END;
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                    end
                end

                S_END: begin
                    if (!start_i) begin
                        state    <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end

                default: begin
                    state    <= S_FREE;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div - scoreboard bench for ex_div.
// The stimulus pushes the expected {remainder, quotient} and the expected latency
// when it issues a division. A monitor pops the entry when ready_o rises.
// The monitor also checks that the result stays stable while ready_o is high.

module tb_ex_div;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_div_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           start_i;
    logic           annul_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;

    ex_div #(.DATA_W(W), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          e0;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e_mon;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        prev_ready = 1'b0;
    logic [63:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain integer division truncating toward zero.
    // A zero divisor gives an all-zero result.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic scramble();
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
    endtask

    always @(negedge clk) begin
        if (ready_o && !prev_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 64'(ready_o), 64'd0);
            end else begin
                e_mon = sb_q.pop_front();
                check("result", result_o, e_mon.res);
                check("latency", 64'(cyc - e_mon.e0), 64'(e_mon.lat));
                held = e_mon.res;
            end
        end else if (ready_o) begin
            check("hold_stable", result_o, held);
        end
        prev_ready = ready_o;
    end

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
        exp_t e;
        bit   got;
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        e.res = model(a, b, s);
        e.e0  = cyc + 1;
        e.lat = (b == 0) ? 2 : W + 1;
        sb_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            scramble();
            if (ready_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("timeout", 64'(ready_o), 64'd1);
            start_i = 1'b0;
            if (sb_q.size() > 0) void'(sb_q.pop_back());
            @(negedge clk);
            return;
        end
        repeat (hold) begin
            @(negedge clk);
            scramble();
        end
        start_i = 1'b0;
        @(negedge clk);
        check("drop_ready", 64'(ready_o), 64'd0);
        check("drop_result", result_o, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          saw;
        logic [31:0] a, b;
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        signed_div_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;

        do_div(32'd100, 32'd7, 1'b0, 3);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1);
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        do_div(32'd1234, 32'd0, 1'b1, 2);
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1);

        // Annul at E10: the division is cancelled and must never complete.
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_result", result_o, 64'd0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) saw = 1'b1;
        end
        check("annul_no_ready", 64'(saw), 64'd0);
        do_div(32'd9, 32'd3, 1'b0, 1);

        // Reset at E20 of a division.
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        do_div(32'd15, 32'd4, 1'b0, 2);

        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2);

        for (int k = 0; k < 20; k++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            do_div(a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
